gate_test_sequencer: RTL and testbench
======================================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, meaning wait cycles between driving a vector and sampling y_in; legal range 0..15.
REQ-002 Parameter TRUTH, default 4'b1000, meaning expected y for vector index {a,b}; the default is the 2-input AND truth table.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 Port start  input  1  request one full test run; sampled on the rising edge of clk.
REQ-006 Port y_in  input  1  output of the 2-input gate under test.
REQ-007 Port a_out  output  1  input A driven to the gate under test.
REQ-008 Port b_out  output  1  input B driven to the gate under test.
REQ-009 Port busy  output  1  high while a run is in progress.
REQ-010 Port done  output  1  one-cycle pulse marking run completion.
REQ-011 Port pass  output  1  high when the last completed run had zero mismatches.
REQ-012 Port fail_vec  output  4  bit i set means vector i mismatched in the last run.
REQ-013 Port err_count  output  3  number of mismatched vectors in the last run (0..4).

Function
REQ-014 The FSM SHALL have the states IDLE, APPLY, SETTLE, CHECK and FINISH, with a 2-bit vector index idx and a 4-bit settle counter.
REQ-015 In IDLE with start=1, the FSM SHALL go to APPLY, set idx=0, and clear fail_vec, err_count and pass in the same edge.
REQ-016 start SHALL be ignored in every state other than IDLE; there is no queuing.
REQ-017 a_out SHALL equal idx[1] and b_out SHALL equal idx[0], registered, from APPLY through CHECK of that vector.
REQ-018 APPLY SHALL last exactly one cycle, then go to SETTLE and load the counter with SETTLE_CYCLES.
REQ-019 If SETTLE_CYCLES=0, APPLY SHALL go directly to CHECK.
REQ-020 SETTLE SHALL decrement the counter each cycle and go to CHECK after exactly SETTLE_CYCLES cycles.
REQ-021 In CHECK (one cycle), the block SHALL sample y_in. If y_in != TRUTH[idx], it SHALL set fail_vec[idx] and increment err_count.
REQ-022 In CHECK, if idx=3 the FSM SHALL go to FINISH; otherwise it SHALL increment idx and go to APPLY. idx never wraps inside a run.
REQ-023 Per-vector latency SHALL be SETTLE_CYCLES+2 cycles; a full run SHALL be 4*(SETTLE_CYCLES+2) cycles from start acceptance to FINISH entry.
REQ-024 FINISH SHALL last one cycle with done=1 and pass=(err_count==0) (including the final CHECK update), then return to IDLE.
REQ-025 busy SHALL be 1 in APPLY, SETTLE and CHECK, and 0 in IDLE and FINISH.
REQ-026 pass, fail_vec and err_count SHALL hold their values in IDLE until the next accepted start.
REQ-027 a_out and b_out SHALL hold their last driven values in FINISH and IDLE.
REQ-028 err_count SHALL saturate at 4; by construction it cannot exceed 4.

Reset
REQ-029 When rst_n=0 at any time, including mid-run, the FSM SHALL immediately go to IDLE with idx=0, counter=0 and all outputs 0 (a_out, b_out, busy, done, pass, fail_vec, err_count).
REQ-030 After rst_n deasserts, a start in a later cycle SHALL begin a clean run; partial results from an aborted run SHALL be discarded.

Verification
REQ-031 With SETTLE_CYCLES=4, a correct AND gate, and a start pulse, the bench SHALL see busy for 24 cycles, then done for 1 cycle, with pass=1, fail_vec=0000 and err_count=0.
REQ-032 With the gate replaced by an OR gate (TRUTH default), the bench SHALL see pass=0, fail_vec=0110 and err_count=2.
REQ-033 With y_in stuck at 1, the bench SHALL see fail_vec=0111, err_count=3 and pass=0. A following run with the correct gate SHALL report pass=1 and fail_vec=0000.
REQ-034 If start is pulsed again at cycle 10 of a run, that pulse SHALL be ignored; exactly one done pulse SHALL occur, at the original cycle 25.
REQ-035 If rst_n is pulled low at cycle 13 of a run, all outputs SHALL be 0 asynchronously. No done pulse SHALL occur afterwards until a new start is given.
REQ-036 With SETTLE_CYCLES=0, the run SHALL be 8 cycles with the a_out/b_out sequence 00, 01, 10, 11, each held for 2 cycles.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: exhaustively drives a 2-input gate and checks y_in against a truth table
module gate_test_sequencer #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] TRUTH         = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, FINISH} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state, state_nx;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       mism;

    assign mism  = y_in != TRUTH[idx];
    assign a_out = idx[1];
    assign b_out = idx[0];
    assign busy  = state == APPLY || state == SETTLE || state == CHECK;
    assign done  = state == FINISH;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? APPLY : IDLE;
            APPLY:   state_nx = SETTLE_LD == 4'd0 ? CHECK : SETTLE;
            SETTLE:  state_nx = cnt <= 4'd1 ? CHECK : SETTLE;
            CHECK:   state_nx = idx == 2'd3 ? FINISH : APPLY;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // vector index, settle counter and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            cnt       <= 4'd0;
            pass      <= 1'b0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx       <= 2'd0;
                    pass      <= 1'b0;
                    fail_vec  <= 4'd0;
                    err_count <= 3'd0;
                end
                APPLY:  cnt <= SETTLE_LD;
                SETTLE: cnt <= cnt - 4'd1;
                CHECK: begin
                    if (mism) begin
                        fail_vec[idx] <= 1'b1;
                        err_count     <= err_count >= 3'd4 ? 3'd4 : err_count + 3'd1;
                    end
                    if (idx != 2'd3) idx  <= idx + 2'd1;
                    else             pass <= err_count == 3'd0 && !mism;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: directed runs against modelled AND/OR/stuck gates with a result scoreboard
module tb_gate_test_sequencer;
    localparam logic [3:0] TRUTH_TB = 4'b1000;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       start0 = 0, start1 = 0;
    logic       y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] fv0, fv1;
    logic [2:0] err0, err1;
    int         mode = 0;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic a, input logic b);
        return m == 0 ? (a & b) : m == 1 ? (a | b) : 1'b1;
    endfunction

    assign y0 = gate(mode, a0, b0);
    assign y1 = gate(mode, a1, b1);

    gate_test_sequencer #(.SETTLE_CYCLES(4), .TRUTH(TRUTH_TB)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_vec(fv0), .err_count(err0)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(0), .TRUTH(TRUTH_TB)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_vec(fv1), .err_count(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expect_result(input int m);
        logic [3:0] fv = 4'd0;
        logic [2:0] e  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v = 2'(i);
            fv[i] = gate(m, v[1], v[0]) != TRUTH_TB[i];
            e = e + 3'(fv[i]);
        end
        return {e == 3'd0, fv, e};
    endfunction

    task automatic run(input bit sel, input int m, input bit restart);
        int         per = sel ? 2 : 6;
        int         busy_n = 0, done_at = 0, extra = 0;
        logic [7:0] exp_r, res;
        mode = m;
        exp_q.push_back(expect_result(m));
        if (sel) start1 = 1; else start0 = 1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (sel) start1 = 0; else start0 = (restart && k == 10);
            if (sel ? busy1 : busy0) busy_n++;
            if (k <= 4 * per) check("ab_seq", sel ? {a1, b1} : {a0, b0}, 32'((k - 1) / per));
            if (sel ? done1 : done0) begin
                done_at = k;
                break;
            end
        end
        start0 = 0;
        check("done_seen", done_at != 0, 1);
        check("busy_len", busy_n, 4 * per);
        check("done_at", done_at, 4 * per + 1);
        exp_r = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        res = sel ? {pass1, fv1, err1} : {pass0, fv0, err0};
        check("result", res, exp_r);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sel ? (done1 || busy1) : (done0 || busy0)) extra++;
        end
        check("quiet_after", extra, 0);
        res = sel ? {pass1, fv1, err1} : {pass0, fv0, err0};
        check("hold", res, exp_r);
    endtask

    initial begin
        int late_done = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset0", {a0, b0, busy0, done0, pass0, fv0, err0}, 0);
        check("reset1", {a1, b1, busy1, done1, pass1, fv1, err1}, 0);
        rst_n = 1;
        @(negedge clk);
        run(0, 0, 0);
        run(0, 1, 0);
        run(0, 2, 0);
        run(0, 0, 0);
        run(0, 0, 1);
        mode = 0;
        start0 = 1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start0 = 0;
        end
        check("mid_busy", busy0, 1);
        rst_n = 0;
        #1;
        check("abort_outs", {a0, b0, busy0, done0, pass0, fv0, err0}, 0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0 || busy0) late_done++;
        end
        check("no_done_after_abort", late_done, 0);
        run(0, 1, 0);
        run(1, 0, 0);
        run(1, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
